// File: rtl/dsp_clk_pkg.sv
// Shared types and default timing for the DSP clock generator and its lock synchronizer.
package dsp_clk_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_RUN       = 2'd2
  } clk_state_e;

  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_CE_DIV             = 24;
  localparam int DEF_SLOTS              = 32;
  localparam int DEF_SAMPLE_CLKS        = DEF_CE_DIV * DEF_SLOTS;

  // A terminal value of 0 still needs a 1-bit counter.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dsp_sync2.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module dsp_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/dsp_clkgen.sv
// DSP/SPC timebase: PLL lock qualification, ce strobe, slot counter and sample tick.
// Define DSP_CLKGEN_PAUSE_EN to build in the sample-aligned pause/resume handshake.
//   state        | meaning
//   ST_WAIT_LOCK | rst_out held, waiting for synchronized lock
//   ST_STABLE    | rst_out held, counting continuous lock cycles
//   ST_RUN       | rst_out released, phase/slot timebase running
module dsp_clkgen
  import dsp_clk_pkg::*;
#(
  parameter  int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter  int CE_DIV             = DEF_CE_DIV,
  parameter  int SLOTS              = DEF_SLOTS,
  localparam int SLOT_W             = cnt_w(SLOTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lock,
  input  logic              pause_req,
  output logic              rst_out,
  output logic              ce,
  output logic [SLOT_W-1:0] slot,
  output logic              sample_tick,
  output logic              pause_ack
);

  localparam int PH_W  = cnt_w(CE_DIV);
  localparam int STB_W = cnt_w(LOCK_STABLE_CYCLES);

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CE_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
  localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(LOCK_STABLE_CYCLES - 1);

  clk_state_e r_state, w_state_nxt;

  logic              w_lock_s;
  logic              w_hold;
  logic [STB_W-1:0]  r_stable, w_stable_nxt;
  logic [PH_W-1:0]   r_phase, w_phase_nxt;
  logic [SLOT_W-1:0] r_slot, w_slot_nxt;
  logic              r_ce, w_ce_nxt;
  logic              r_tick, w_tick_nxt;
  logic              r_rst_out;

  dsp_sync2 u_lock_sync (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (lock),
    .o_q   (w_lock_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_WAIT_LOCK;
      r_stable  <= '0;
      r_phase   <= '0;
      r_slot    <= '0;
      r_ce      <= 1'b0;
      r_tick    <= 1'b0;
      r_rst_out <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_stable  <= w_stable_nxt;
      r_phase   <= w_phase_nxt;
      r_slot    <= w_slot_nxt;
      r_ce      <= w_ce_nxt;
      r_tick    <= w_tick_nxt;
      r_rst_out <= (w_state_nxt != ST_RUN);
    end
  end

  // Everything not explicitly advanced falls back to zero, so leaving RUN or
  // freezing clears the timebase without extra terms.
  always_comb begin
    w_state_nxt  = r_state;
    w_stable_nxt = '0;
    w_phase_nxt  = '0;
    w_slot_nxt   = '0;
    w_ce_nxt     = 1'b0;
    w_tick_nxt   = 1'b0;
    case (r_state)
      ST_WAIT_LOCK: begin
        if (w_lock_s) w_state_nxt = ST_STABLE;
      end
      ST_STABLE: begin
        if (!w_lock_s)               w_state_nxt  = ST_WAIT_LOCK;
        else if (r_stable == STB_LAST) w_state_nxt  = ST_RUN;
        else                         w_stable_nxt = r_stable + 1'b1;
      end
      ST_RUN: begin
        if (!w_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (!w_hold) begin
          w_phase_nxt = (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
          w_slot_nxt  = r_slot;
          if (r_ce) w_slot_nxt = (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;
          w_ce_nxt   = (w_phase_nxt == PH_LAST);
          w_tick_nxt = w_ce_nxt && (w_slot_nxt == SLOT_LAST);
        end
      end
      default: w_state_nxt = ST_WAIT_LOCK;
    endcase
  end

`ifdef DSP_CLKGEN_PAUSE_EN
  logic r_paused;

  // Freeze on the edge that ends a sample_tick cycle; stay frozen while requested.
  assign w_hold = r_paused | (r_tick & pause_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_paused <= 1'b0;
    else       r_paused <= (r_state == ST_RUN) & w_lock_s & pause_req & w_hold;
  end

  assign pause_ack = r_paused;
`else
  logic w_unused_pause_req;

  assign w_unused_pause_req = pause_req;
  assign w_hold             = 1'b0;
  assign pause_ack          = 1'b0;
`endif

  assign rst_out     = r_rst_out;
  assign ce          = r_ce;
  assign slot        = r_slot;
  assign sample_tick = r_tick;

endmodule

// File: tb/tb_dsp_clkgen.sv
// Self-checking bench for dsp_clkgen: vector table, hand-written corner sequences, and
// randomized lock/pause/reset traffic scored against an arithmetic timebase model.
`timescale 1ns/1ps
module tb_dsp_clkgen;

  localparam int LSC    = 1024;
  localparam int CE     = 24;
  localparam int SL     = 32;
  localparam int SAMPLE = CE * SL;
`ifdef DSP_CLKGEN_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lock = 1'b1;
  logic       pause_req = 1'b0;
  logic       rst_out, ce, sample_tick, pause_ack;
  logic [4:0] slot;

  int n_tests = 0;
  int n_fail  = 0;

  dsp_clkgen #(
    .LOCK_STABLE_CYCLES (LSC),
    .CE_DIV             (CE),
    .SLOTS              (SL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .lock        (lock),
    .pause_req   (pause_req),
    .rst_out     (rst_out),
    .ce          (ce),
    .slot        (slot),
    .sample_tick (sample_tick),
    .pause_ack   (pause_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. m_l_now/m_l_prev: run length of edges that sampled lock high,
  // as of the latest edge and the one before. The timebase is released once lock
  // has been seen high on LSC+1 consecutive edges ending two edges back (two edges
  // of synchronizer delay, one edge to leave WAIT_LOCK, LSC stable counts).
  // m_k indexes clock cycles since the timebase (re)started: ce on k%CE==CE-1,
  // slot = (k/CE)%SL, sample_tick on the last ce of a sample.
  int m_l_now = 0, m_l_prev = 0, m_k = 0;
  bit m_run = 1'b0, m_paused = 1'b0;
  bit nrun, tick_now;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_l_now  = 0;
      m_l_prev = 0;
      m_k      = 0;
      m_run    = 1'b0;
      m_paused = 1'b0;
    end else begin
      nrun     = (m_l_prev >= LSC + 1);
      tick_now = m_run && !m_paused && (m_k % SAMPLE == SAMPLE - 1);
      if (!nrun) begin
        m_k = 0; m_paused = 1'b0;
      end else if (!m_run) begin
        m_k = 0;
      end else if (m_paused) begin
        if (!pause_req) m_paused = 1'b0;
        m_k = 0;
      end else if (PAUSE_EN && tick_now && pause_req) begin
        m_paused = 1'b1; m_k = 0;
      end else begin
        m_k++;
      end
      m_run    = nrun;
      m_l_prev = m_l_now;
      m_l_now  = lock ? m_l_now + 1 : 0;
    end
  end

  bit e_act, e_ce;
  int e_slot;

  always @(negedge clk) begin
    e_act  = m_run && !m_paused;
    e_ce   = e_act && (m_k % CE == CE - 1);
    e_slot = e_act ? (m_k / CE) % SL : 0;
    check("sb_rst_out", rst_out, !m_run);
    check("sb_ce", ce, e_ce);
    check("sb_slot", slot, e_slot);
    check("sb_sample_tick", sample_tick, e_ce && e_slot == SL - 1);
    check("sb_pause_ack", pause_ack, m_paused);
  end

  typedef struct {
    string name;
    bit    rst;
    bit    lk;
    bit    preq;
    int    cycles;
    bit    exp_rst_out;
    bit    exp_ack;
    int    exp_slot;
    int    exp_ces;
  } vec_t;

  vec_t vt[$];

  task automatic add_vec(input string name, input bit rst, input bit lk, input bit preq,
                         input int cycles, input bit e_rst, input bit e_ack,
                         input int e_slot_v, input int e_ces);
    vec_t v;
    v.name = name; v.rst = rst; v.lk = lk; v.preq = preq; v.cycles = cycles;
    v.exp_rst_out = e_rst; v.exp_ack = e_ack; v.exp_slot = e_slot_v; v.exp_ces = e_ces;
    vt.push_back(v);
  endtask

  int n, nce, lock_hold;
  bit got;

  initial begin
    // Cycle counts are edges after the inputs change (inputs move 2 ns after posedge).
    add_vec("reset",         1, 1, 0, 5,    1, 0,        0,               0);
    add_vec("lock_wait",     0, 1, 0, 1026, 1, 0,        0,               0);
    add_vec("rst_release",   0, 1, 0, 1,    0, 0,        0,               0);
    add_vec("first_ce",      0, 1, 0, 23,   0, 0,        0,               1);
    add_vec("sample0",       0, 1, 0, 745,  0, 0,        0,               31);
    add_vec("to_slot17",     0, 1, 0, 408,  0, 0,        17,              17);
    add_vec("lock_drop",     0, 0, 0, 3,    1, 0,        0,               0);
    add_vec("relock500",     0, 1, 0, 500,  1, 0,        0,               0);
    add_vec("lock_glitch",   0, 0, 0, 1,    1, 0,        0,               0);
    add_vec("relock_full",   0, 1, 0, 1026, 1, 0,        0,               0);
    add_vec("rerun",         0, 1, 0, 1,    0, 0,        0,               0);
    add_vec("to_slot5",      0, 1, 0, 120,  0, 0,        5,               5);
    add_vec("pause_pending", 0, 1, 1, 647,  0, 0,        31,              27);
    add_vec("pause_freeze",  0, 1, 1, 1,    0, PAUSE_EN, 0,               0);
    add_vec("paused",        0, 1, 1, 100,  0, PAUSE_EN, PAUSE_EN ? 0 : 4, PAUSE_EN ? 0 : 4);
    add_vec("resume",        0, 1, 0, 1,    0, 0,        PAUSE_EN ? 0 : 4, 0);
    add_vec("resume_ce",     0, 1, 0, 23,   0, 0,        PAUSE_EN ? 0 : 5, 1);

    @(posedge clk); #2;
    foreach (vt[i]) begin
      reset = vt[i].rst; lock = vt[i].lk; pause_req = vt[i].preq;
      nce = 0;
      for (int c = 0; c < vt[i].cycles; c++) begin
        @(posedge clk); #1;
        if (ce) nce++;
      end
      check({vt[i].name, "_rst_out"}, rst_out, vt[i].exp_rst_out);
      check({vt[i].name, "_pause_ack"}, pause_ack, vt[i].exp_ack);
      check({vt[i].name, "_slot"}, slot, vt[i].exp_slot);
      check({vt[i].name, "_ce_count"}, nce, vt[i].exp_ces);
      #1;
    end

    // Asynchronous reset mid-sample: outputs drop without waiting for a clock.
    pause_req = 1'b0;
    reset = 1'b1; #1;
    check("async_rst_out", rst_out, 1);
    check("async_ce", ce, 0);
    check("async_tick", sample_tick, 0);
    check("async_slot", slot, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    n = 0;
    for (int c = 1; c <= LSC + 100; c++) begin
      @(posedge clk); #1;
      if (!rst_out) begin n = c; break; end
    end
    check("rst_out_latency", n, 2 + 1 + LSC);
    #1;
    n = 0;
    for (int c = 1; c <= 4 * CE; c++) begin
      @(posedge clk); #1;
      if (ce) begin n = c; break; end
    end
    check("first_ce_latency", n, CE - 1);
    #1;

`ifdef DSP_CLKGEN_PAUSE_EN
    pause_req = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 2 * SAMPLE && !got; c++) begin
      @(posedge clk); #1;
      got = pause_ack;
    end
    check("pause_ack_reached", got, 1);
    @(posedge clk); #2;
`endif

    // Reset while paused (or mid-sample without pause support).
    reset = 1'b1; #1;
    check("midpause_rst_out", rst_out, 1);
    check("midpause_ack", pause_ack, 0);
    check("midpause_ce", ce, 0);
    pause_req = 1'b0;

    @(posedge clk); #2;
    reset = 1'b0; lock = 1'b1; lock_hold = 0;
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 39) == 0) pause_req = ~pause_req;
      if (lock_hold > 0) begin
        lock_hold--;
        if (lock_hold == 0) lock = 1'b1;
      end else if ($urandom_range(0, 6999) == 0) begin
        lock = 1'b0;
        lock_hold = $urandom_range(1, 3);
      end
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 9999) == 0) reset = 1'b1;
    end

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
